// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential restoring divider:
// default operand width, FSM state type and state codes.
package seq_divider_pkg;

    localparam int DEFAULT_WIDTH = 16;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE   = 3'd0;
    localparam state_t S_LOAD_A = 3'd1;
    localparam state_t S_LOAD_B = 3'd2;
    localparam state_t S_CHECK  = 3'd3;
    localparam state_t S_CALC   = 3'd4;
    localparam state_t S_DONE   = 3'd5;

    function automatic int cnt_bits(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/seq_divider_data_path.sv
// Divider datapath: operand registers, partial remainder,
// quotient shift register, trial subtractor and step counter.
module div_data_path
    import seq_divider_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load_a,
    input  logic             i_load_b,
    input  logic             i_check,
    input  logic             i_calc,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_quotient,
    output logic [WIDTH-1:0] o_remainder,
    output logic             o_div_by_zero,
    output logic             o_b_zero,
    output logic             o_cnt_last
);

    localparam int CW = cnt_bits(WIDTH);
    localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_r;
    logic             r_dbz;
    logic [CW-1:0]    r_cnt;

    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_diff;
    logic             w_neg;

    // R < D holds between steps, so a WIDTH+1 bit difference
    // carries the borrow in its top bit.
    assign w_shift = {r_r, r_q[WIDTH-1]};
    assign w_diff  = w_shift - {1'b0, r_b};
    assign w_neg   = w_diff[WIDTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a   <= '0;
            r_b   <= '0;
            r_q   <= '0;
            r_r   <= '0;
            r_dbz <= 1'b0;
            r_cnt <= '0;
        end else begin
            if (i_load_a) begin
                r_a   <= i_data;
                r_q   <= '0;
                r_r   <= '0;
                r_dbz <= 1'b0;
            end
            if (i_load_b) begin
                r_b <= i_data;
            end
            if (i_check) begin
                if (o_b_zero) begin
                    r_q   <= '1;
                    r_r   <= r_a;
                    r_dbz <= 1'b1;
                end else begin
                    r_q   <= r_a;
                    r_r   <= '0;
                    r_cnt <= CNT_INIT;
                end
            end
            if (i_calc) begin
                r_cnt <= r_cnt - CNT_ONE;
                if (!w_neg) begin
                    r_r <= w_diff[WIDTH-1:0];
                    r_q <= {r_q[WIDTH-2:0], 1'b1};
                end else begin
                    r_r <= w_shift[WIDTH-1:0];
                    r_q <= {r_q[WIDTH-2:0], 1'b0};
                end
            end
        end
    end

    assign o_quotient    = r_q;
    assign o_remainder   = r_r;
    assign o_div_by_zero = r_dbz;
    assign o_b_zero      = (r_b == '0);
    assign o_cnt_last    = (r_cnt == CNT_ONE);

endmodule

// File: rtl/seq_divider.sv
// Sequential unsigned divider: operands arrive on a shared bus,
// one restoring shift-subtract step per cycle in CALC.
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    state_t r_state;
    state_t w_next;

    logic w_load_a;
    logic w_load_b;
    logic w_check;
    logic w_calc;
    logic w_b_zero;
    logic w_cnt_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:   w_next = start ? S_LOAD_A : S_IDLE;
            S_LOAD_A: w_next = S_LOAD_B;
            S_LOAD_B: w_next = S_CHECK;
            S_CHECK:  w_next = w_b_zero ? S_DONE : S_CALC;
            S_CALC:   w_next = w_cnt_last ? S_DONE : S_CALC;
            S_DONE:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    assign w_load_a = (r_state == S_LOAD_A);
    assign w_load_b = (r_state == S_LOAD_B);
    assign w_check  = (r_state == S_CHECK);
    assign w_calc   = (r_state == S_CALC);

    assign busy = (r_state != S_IDLE);
    assign done = (r_state == S_DONE);

    div_data_path #(
        .WIDTH(WIDTH)
    ) u_dp (
        .clk          (clk),
        .rst          (rst),
        .i_load_a     (w_load_a),
        .i_load_b     (w_load_b),
        .i_check      (w_check),
        .i_calc       (w_calc),
        .i_data       (data_in),
        .o_quotient   (quotient),
        .o_remainder  (remainder),
        .o_div_by_zero(div_by_zero),
        .o_b_zero     (w_b_zero),
        .o_cnt_last   (w_cnt_last)
    );

endmodule

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 Parameter WIDTH, default 16, operand/result width in bits.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 start  input  1  request a division; sampled only in IDLE.
REQ-005 data_in  input  WIDTH  shared operand bus: dividend, then divisor, on consecutive cycles.
REQ-006 quotient  output  WIDTH  result quotient, held until next accepted start.
REQ-007 remainder  output  WIDTH  result remainder, held until next accepted start.
REQ-008 busy  output  1  high in every state except IDLE.
REQ-009 done  output  1  one-cycle pulse; results valid.
REQ-010 div_by_zero  output  1  high with done when divisor was 0; held until next accepted start.

Function
REQ-011 FSM states: IDLE, LOAD_A, LOAD_B, CHECK, CALC, DONE; one-hot or binary encoding permitted.
REQ-012 IDLE: start=1 -> LOAD_A; start=0 -> stay; quotient/remainder/div_by_zero hold.
REQ-013 LOAD_A: capture data_in as dividend; clear quotient, remainder, div_by_zero -> LOAD_B.
REQ-014 LOAD_B: capture data_in as divisor -> CHECK.
REQ-015 CHECK: divisor==0 -> DONE with div_by_zero=1, quotient=all ones, remainder=dividend; else load iteration counter with WIDTH, partial remainder=0 -> CALC.
REQ-016 CALC: each cycle performs one restoring shift-subtract step: {R,Q} shifted left 1, R-D computed on WIDTH+1 bits; if non-negative R<=R-D and Q LSB<=1, else Q LSB<=0; counter decrements.
REQ-017 CALC exits to DONE on the cycle the counter's last step (WIDTH-th) completes; exactly WIDTH CALC cycles.
REQ-018 DONE: done=1 for exactly one cycle -> IDLE unconditionally.
REQ-019 Latency: start sampled at edge 0 -> done high after edge WIDTH+3 (edge 19 for WIDTH=16); divide-by-zero -> done high after edge 3.
REQ-020 start while busy=1 ignored; no queuing.
REQ-021 start=1 in the DONE cycle ignored; start sampled in following IDLE cycle begins a new operation (back-to-back minimum period WIDTH+5 cycles).
REQ-022 Results unsigned: dividend = quotient*divisor + remainder, remainder < divisor for all nonzero divisors.
REQ-023 data_in ignored outside LOAD_A and LOAD_B.

Reset
REQ-024 rst=1 at any edge, any state (including mid-CALC) -> IDLE next cycle; quotient=0, remainder=0, done=0, busy=0, div_by_zero=0, counter=0.
REQ-025 rst dominates start in the same cycle; no partial result is ever reported after reset.

Structure
REQ-026 Shared package holds the FSM state typedef and the default WIDTH constant.
REQ-027 Datapath (operand registers, partial remainder, subtractor, counter) sits in one sub-module div_data_path, driven by control enables from the seq_divider FSM; counter-zero flag returned to FSM.

Verification
REQ-028 data_in 17 then 5 -> quotient=3, remainder=2, div_by_zero=0, done after edge 19.
REQ-029 data_in 5 then 17 -> quotient=0, remainder=5; 0xFFFF then 1 -> quotient=0xFFFF, remainder=0.
REQ-030 data_in 100 then 0 -> div_by_zero=1, quotient=0xFFFF, remainder=100, done after edge 3.
REQ-031 rst pulsed during 8th CALC cycle -> all outputs 0 next cycle, no done pulse; following 40/7 -> quotient=5, remainder=5.
REQ-032 start held high throughout two operations (17/5, then 9/3) -> second accepted only in IDLE after done; results 3/2 then 3/0, mid-op start ignored.
REQ-033 Randomised 1000 operand pairs against reference model q=a/b, r=a%b, zero divisor included.
